multiword_mem_seq: RTL
======================

// Module: multiword_mem_seq
// PURPOSE
//  Parametrised successor to the two-cycle LDW/SDW sequencing in the CPU top. Moves 1..MAX_BEATS
//  consecutive words between memory and consecutive registers. Memory uses a req/ready
//  handshake with any number of wait states. Sits between control_unit/datapath and the data memory port.
// PARAMETERS
//  DATA_W     32  memory/register data width
//  ADDR_W     32  memory address width (word-addressed)
//  REG_W      4   register index width; register file has 2**REG_W entries
//  MAX_BEATS  8   maximum words per transfer (>=1)
//  ADDR_STEP  1   address increment per beat
//  TIMEOUT    64  wait cycles per beat before abort (used only with MSEQ_TIMEOUT_EN)
// PORTS
//  clk        in   1                    clock, all state updates on rising edge
//  rst        in   1                    synchronous, active-high reset
//  start      in   1                    request pulse; sampled only in IDLE
//  is_store   in   1                    1=store (regs->mem), 0=load (mem->regs)
//  base_addr  in   ADDR_W               address of beat 0
//  num_beats  in   $clog2(MAX_BEATS+1)  word count, 0..MAX_BEATS
//  first_reg  in   REG_W                register for beat 0; beat k uses first_reg+k
//  busy       out  1                    high in any state other than IDLE
//  done       out  1                    one-cycle pulse at the end of every accepted request
//  exception  out  1                    one-cycle pulse alongside done when a request is rejected or aborted
//  mem_req    out  1                    memory access valid
//  mem_we     out  1                    write strobe; qualified by mem_req
//  mem_addr   out  ADDR_W               current beat address
//  mem_wdata  out  DATA_W               store data = rf_rd_data (combinational pass-through)
//  mem_rdata  in   DATA_W               load data; valid when mem_ready=1
//  mem_ready  in   1                    completes the current beat when mem_req=1
//  rf_rd_addr out  REG_W                register read index for store data
//  rf_rd_data in   DATA_W               register read data (combinational read)
//  rf_wr_en   out  1                    = mem_req & mem_ready & ~mem_we & ~rst
//  rf_wr_addr out  REG_W                current beat register
//  rf_wr_data out  DATA_W               = mem_rdata
// BEHAVIOUR
//  States: IDLE, ACCESS, DONE.
//  Reset: state=IDLE; busy, done, exception, mem_req, mem_we = 0; mem_addr, rf_rd_addr = 0; beat counter = 0.
//  IDLE + start: latch is_store, base_addr, num_beats, first_reg.
//   - num_beats == 0: go to DONE; no access; no exception.
//   - num_beats > MAX_BEATS, or first_reg+num_beats-1 > 2**REG_W-1: go to DONE with exception=1; no access.
//   - otherwise: go to ACCESS.
//  ACCESS: mem_req=1, mem_we=is_store, mem_addr=base_addr+k*ADDR_STEP (modulo 2**ADDR_W),
//   rf_rd_addr = rf_wr_addr = first_reg+k.
//   - All outputs stay stable while mem_ready=0.
//   - On mem_ready=1, beat k completes; a load writes the register in that same cycle.
//   - k advances; after the last beat, go to DONE.
//  DONE: done=1 for one cycle, then IDLE. busy drops in the same cycle as the IDLE transition.
//  Latency: start at edge t, zero wait states, N beats -> beats at t+1..t+N, done at t+N+1.
//  start while busy is ignored, not queued. A start in the same cycle as done is ignored.
//  rst mid-transfer: IDLE at that edge; no rf write during the reset cycle;
//   completed beats are not rolled back; no done pulse.
// CONFIGURATION
//  MSEQ_TIMEOUT_EN defined: a per-beat wait counter resets on each ready.
//   If it reaches TIMEOUT with mem_ready=0: drop mem_req, go to DONE with done=1 and exception=1.
//   The remaining beats are not issued.
//  MSEQ_TIMEOUT_EN not defined: no counter; ACCESS waits indefinitely; TIMEOUT is unused.
// STRUCTURE
//  Shared package mseq_pkg:
//   - state enum (IDLE/ACCESS/DONE) with 2-bit encoding
//   - exception-cause constants (RANGE, TIMEOUT) for debug visibility
//   - BEAT_W function = $clog2(MAX_BEATS+1)
//  One sub-module, mseq_addr_gen: beat counter plus address/register-index generation
//   (load, advance, last-beat flag).
// TESTING
//  - Load, N=2, base=0x10, first_reg=4, zero wait:
//    rf writes r4=mem[0x10], r5=mem[0x11] at t+1, t+2; done at t+3; exception=0.
//  - Store, N=4, mem_ready low 2 cycles on beat 1:
//    mem_addr/mem_wdata held stable; 4 writes at base..base+3; done at t+7.
//  - first_reg=14, N=3:
//    exception and done at t+1; mem_req never asserted.
//  - N=0:
//    done at t+1, no exception, no memory or register activity.
//  - rst asserted during beat 2 of 5:
//    next cycle busy=0, mem_req=0, no done; a new start is then accepted normally.
//  - MSEQ_TIMEOUT_EN, TIMEOUT=8, mem_ready held 0:
//    done=exception=1 eight cycles into beat 0; with the macro undefined, busy stays 1.

Source files
------------

// File: rtl/mseq_pkg.sv
// Shared types for the multi-word load/store sequencer: FSM states, exception causes
// and the beat-count width helper.
package mseq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Held until the next accepted request so a debugger can see why exception fired
  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_RANGE   = 2'd1,
    EXC_TIMEOUT = 2'd2
  } exc_cause_t;

  function automatic int beat_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/multiword_mem_seq_if.sv
// Request, memory-port and register-file signals of the multi-word sequencer.
// master = sequencer side, slave = control/memory/register-file side.
interface multiword_mem_seq_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_W     = 4,
  parameter int MAX_BEATS = 8
) ();
  localparam int BEAT_W = mseq_pkg::beat_w(MAX_BEATS);

  logic              start;
  logic              is_store;
  logic [ADDR_W-1:0] base_addr;
  logic [BEAT_W-1:0] num_beats;
  logic [REG_W-1:0]  first_reg;
  logic              busy;
  logic              done;
  logic              exception;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [REG_W-1:0]  rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_wr_en;
  logic [REG_W-1:0]  rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  modport master (
    input  start, is_store, base_addr, num_beats, first_reg,
    input  mem_rdata, mem_ready, rf_rd_data,
    output busy, done, exception,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    output start, is_store, base_addr, num_beats, first_reg,
    output mem_rdata, mem_ready, rf_rd_data,
    input  busy, done, exception,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/mseq_addr_gen.sv
// Beat counter with memory-address and register-index generation; loads on request
// accept, advances one beat per completed access; no backpressure of its own.
module mseq_addr_gen #(
  parameter int ADDR_W    = 32,
  parameter int REG_W     = 4,
  parameter int BEAT_W    = 4,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [REG_W-1:0]  i_first_reg,
  input  logic [BEAT_W-1:0] i_num_beats,
  output logic [ADDR_W-1:0] o_addr,
  output logic [REG_W-1:0]  o_reg_idx,
  output logic              o_last
);
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] r_num;
  logic [ADDR_W-1:0] r_addr;
  logic [REG_W-1:0]  r_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
      r_num  <= '0;
      r_addr <= '0;
      r_reg  <= '0;
    end else if (i_load) begin
      r_beat <= '0;
      r_num  <= i_num_beats;
      r_addr <= i_base_addr;
      r_reg  <= i_first_reg;
    end else if (i_adv) begin
      r_beat <= r_beat + BEAT_W'(1);
      r_addr <= r_addr + ADDR_W'(ADDR_STEP);
      r_reg  <= r_reg + REG_W'(1);
    end
  end

  assign o_addr    = r_addr;
  assign o_reg_idx = r_reg;
  assign o_last    = (r_beat == r_num - BEAT_W'(1));
endmodule

// File: rtl/multiword_mem_seq.sv
// Moves 1..MAX_BEATS words between memory and consecutive registers; N beats with no wait
// states give done N+1 cycles after start; mem_ready stalls a beat. Option: MSEQ_TIMEOUT_EN.
module multiword_mem_seq
  import mseq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_W     = 4,
  parameter int MAX_BEATS = 8,
  parameter int ADDR_STEP = 1,
  parameter int TIMEOUT   = 64
) (
  input logic               clk,
  input logic               rst,
  multiword_mem_seq_if.master bus
);
  localparam int BEAT_W = beat_w(MAX_BEATS);
  localparam int RC_W   = REG_W + BEAT_W + 1;

  if (MAX_BEATS < 1 || TIMEOUT < 1) begin : g_param_check
    $error("multiword_mem_seq: MAX_BEATS and TIMEOUT must be at least 1");
  end

  state_t            r_state, w_state_nxt;
  exc_cause_t        r_cause, w_cause_nxt;
  logic              r_is_store;
  logic              w_load, w_adv, w_last, w_timeout, w_req;
  logic              w_bad_range;
  logic [RC_W-1:0]   w_last_reg;
  logic [ADDR_W-1:0] w_addr;
  logic [REG_W-1:0]  w_reg;

  mseq_addr_gen #(
    .ADDR_W(ADDR_W), .REG_W(REG_W), .BEAT_W(BEAT_W), .ADDR_STEP(ADDR_STEP)
  ) u_addr_gen (
    .clk(clk), .rst(rst), .i_load(w_load), .i_adv(w_adv),
    .i_base_addr(bus.base_addr), .i_first_reg(bus.first_reg), .i_num_beats(bus.num_beats),
    .o_addr(w_addr), .o_reg_idx(w_reg), .o_last(w_last)
  );

  // Widened so first_reg+num_beats-1 cannot wrap past the top register unnoticed
  assign w_last_reg  = RC_W'(bus.first_reg) + RC_W'(bus.num_beats) - RC_W'(1);
  assign w_bad_range = (bus.num_beats > BEAT_W'(MAX_BEATS)) ||
                       (w_last_reg > RC_W'((1 << REG_W) - 1));

`ifdef MSEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] r_wait;

  always_ff @(posedge clk) begin
    if (rst || r_state != S_ACCESS || bus.mem_ready) r_wait <= '0;
    else                                             r_wait <= r_wait + WAIT_W'(1);
  end

  assign w_timeout = (r_state == S_ACCESS) && !bus.mem_ready &&
                     (r_wait == WAIT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cause    <= EXC_NONE;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      if (w_load) r_is_store <= bus.is_store;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_cause_nxt = EXC_NONE;
          if (bus.num_beats == '0) begin
            w_state_nxt = S_DONE;
          end else if (w_bad_range) begin
            w_state_nxt = S_DONE;
            w_cause_nxt = EXC_RANGE;
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (bus.mem_ready) begin
          w_adv = 1'b1;
          if (w_last) w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_cause_nxt = EXC_TIMEOUT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_req          = (r_state == S_ACCESS);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.exception  = (r_state == S_DONE) && (r_cause != EXC_NONE);
  assign bus.mem_req    = w_req;
  assign bus.mem_we     = w_req && r_is_store;
  assign bus.mem_addr   = w_addr;
  assign bus.mem_wdata  = bus.rf_rd_data;
  assign bus.rf_rd_addr = w_reg;
  assign bus.rf_wr_addr = w_reg;
  assign bus.rf_wr_en   = w_req && bus.mem_ready && !r_is_store && !rst;
  assign bus.rf_wr_data = bus.mem_rdata;
endmodule
